// File: rtl/counter_sched_pkg.sv
// Shared types and default sizes for the counter scheduler.
// Optional run abort is enabled by defining COUNTER_SCHED_ABORT_EN.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin pick starting at the pointer.
// Returns the one-hot winner, its index and a valid flag.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    // Scan ptr, ptr+1, ... mod NREQ and take the first active request
    always_comb begin
        logic [PW:0]   s;
        logic [PW-1:0] j;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        s      = '0;
        j      = '0;
        for (int k = 0; k < NREQ; k++) begin
            s = {1'b0, ptr} + (PW+1)'(k);
            if (s >= (PW+1)'(NREQ)) begin
                s = s - (PW+1)'(NREQ);
            end
            j = s[PW-1:0];
            if (!valid && req[j]) begin
                valid     = 1'b1;
                idx       = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Round-robin owner of one shared interval counter.
// Define COUNTER_SCHED_ABORT_EN to let an owner abort by dropping req.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      value
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [WIDTH-1:0] len_q;

    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   win_idx;
    logic            win_vld;
    logic [WIDTH-1:0] win_len;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req    (req),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .valid  (win_vld)
    );

    // Length of the current arbitration winner
    always_comb begin
        win_len = len[win_idx*WIDTH +: WIDTH];
    end

    // Scheduler FSM with registered grant, done, busy and count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            value <= '0;
            ptr   <= '0;
            owner <= '0;
            len_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= '0;
                    if (win_vld) begin
                        grant <= win_oh;
                        owner <= win_idx;
                        len_q <= win_len;
                        value <= '0;
                        busy  <= 1'b1;
                        ptr   <= (win_idx == PW'(NREQ-1)) ?
                                 '0 : win_idx + 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
                    if (!req[owner]) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        value <= '0;
                        state <= IDLE;
                    end else if (value == len_q) begin
                        done  <= grant;
                        state <= DONE;
                    end else begin
                        value <= value + 1'b1;
                    end
`else
                    if (value == len_q) begin
                        done  <= grant;
                        state <= DONE;
                    end else begin
                        value <= value + 1'b1;
                    end
`endif
                end
                DONE: begin
                    done  <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    value <= '0;
                    state <= IDLE;
                end
                default: begin
                    done  <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    value <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// Directed self-checking bench for counter_sched (NREQ=4, WIDTH=8).
// Abort expectations follow COUNTER_SCHED_ABORT_EN when defined.
module tb_counter_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  value;

    int checks;
    int failures;

    counter_sched #(
        .NREQ  (4),
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .value (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 600) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        req      = 4'b1111;
        len      = '0;

        // reset held with all requests active
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_done",  32'(done),  32'd0);
            chk("rst_busy",  32'(busy),  32'd0);
            chk("rst_value", 32'(value), 32'd0);
        end
        reset = 1'b1;
        tick();
        chk("rel_grant", 32'(grant), 32'h1);
        chk("rel_busy",  32'(busy),  32'd1);
        req = 4'b0000;
        wait_idle();
        tick();

        // single run, requester 2, len 5
        do_reset();
        req        = 4'b0100;
        len[23:16] = 8'd5;
        tick();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_v0",    32'(value), 32'd0);
        for (int v = 1; v <= 5; v++) begin
            tick();
            chk("single_val",  32'(value), 32'(v));
            chk("single_nodn", 32'(done),  32'd0);
        end
        tick();
        chk("single_done",  32'(done),  32'h4);
        chk("single_hold",  32'(value), 32'd5);
        chk("single_gdone", 32'(grant), 32'h4);
        req = 4'b0000;
        tick();
        chk("single_busy0", 32'(busy),  32'd0);
        chk("single_g0",    32'(grant), 32'd0);
        chk("single_d0",    32'(done),  32'd0);

        // fairness, all requesting len 1
        do_reset();
        req = 4'b1111;
        len = 32'h01010101;
        tick();
        chk("fair_g0", 32'(grant), 32'h1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            tick();
            tick();
            chk("fair_gap", 32'(grant), 32'd0);
            tick();
            case (c)
                1: chk("fair_g1", 32'(grant), 32'h2);
                2: chk("fair_g2", 32'(grant), 32'h4);
                3: chk("fair_g3", 32'(grant), 32'h8);
                default: chk("fair_g4", 32'(grant), 32'h1);
            endcase
        end
        req = 4'b0000;
        wait_idle();
        tick();

        // len 0 on requester 1
        do_reset();
        req       = 4'b0010;
        len       = '0;
        tick();
        chk("len0_grant", 32'(grant), 32'h2);
        chk("len0_val",   32'(value), 32'd0);
        tick();
        chk("len0_done",  32'(done),  32'h2);
        req = 4'b0000;
        tick();
        chk("len0_busy",  32'(busy),  32'd0);

        // len 255 on requester 0, len changed after grant is ignored
        req      = 4'b0001;
        len[7:0] = 8'd255;
        tick();
        chk("max_grant", 32'(grant), 32'h1);
        len[7:0] = 8'd3;
        for (int c = 0; c < 255; c++) tick();
        chk("max_val",   32'(value), 32'd255);
        chk("max_nodn",  32'(done),  32'd0);
        tick();
        chk("max_done",  32'(done),  32'h1);
        chk("max_hold",  32'(value), 32'd255);
        req = 4'b0000;
        tick();
        chk("max_busy",  32'(busy),  32'd0);

        // owner drops req mid-run
        do_reset();
        req        = 4'b1000;
        len        = '0;
        len[31:24] = 8'd10;
        tick();
        chk("abt_grant", 32'(grant), 32'h8);
        for (int c = 0; c < 4; c++) tick();
        chk("abt_v4", 32'(value), 32'd4);
        req = 4'b0000;
        tick();
`ifdef COUNTER_SCHED_ABORT_EN
        chk("abt_value", 32'(value), 32'd0);
        chk("abt_grant0", 32'(grant), 32'd0);
        chk("abt_nodone", 32'(done), 32'd0);
        chk("abt_busy",  32'(busy),  32'd0);
`else
        chk("abt_v5", 32'(value), 32'd5);
        for (int c = 0; c < 5; c++) tick();
        chk("abt_v10",  32'(value), 32'd10);
        chk("abt_nodn", 32'(done),  32'd0);
        tick();
        chk("abt_done", 32'(done),  32'h8);
        tick();
        chk("abt_idle", 32'(busy),  32'd0);
`endif
        wait_idle();
        tick();

        // asynchronous reset in the middle of a run
        do_reset();
        req       = 4'b0010;
        len       = '0;
        len[15:8] = 8'd10;
        tick();
        chk("mrst_grant", 32'(grant), 32'h2);
        for (int c = 0; c < 3; c++) tick();
        chk("mrst_v3", 32'(value), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_g0",  32'(grant), 32'd0);
        chk("mrst_b0",  32'(busy),  32'd0);
        chk("mrst_v0",  32'(value), 32'd0);
        chk("mrst_d0",  32'(done),  32'd0);
        tick();
        reset = 1'b1;
        req   = 4'b0011;
        tick();
        chk("mrst_ptr", 32'(grant), 32'h1);
        req = 4'b0000;
        wait_idle();
        tick();
        do_reset();
        req = 4'b0010;
        tick();
        chk("mrst_reg1", 32'(grant), 32'h2);
        chk("mrst_busy", 32'(busy),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one internal WIDTH-bit interval counter between NREQ requesters. Each requester asks for a run of a given length. The block grants one requester at a time, counts from 0 up to the latched length, pulses that requester's done, then releases the counter. It sits between client logic and the free-running counter datapath and exposes the live count value for observation.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, counter and length width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- req  in  NREQ  per-requester request level, held until done (or abort)
- len  in  NREQ*WIDTH  per-requester terminal count; requester i owns bits [i*WIDTH +: WIDTH]
- grant  out  NREQ  one-hot current owner; 0 when idle
- done  out  NREQ  one-cycle pulse to the owner when its run completes
- busy  out  1  counter owned (state RUN or DONE)
- value  out  WIDTH  current count

## Operation
- All outputs are registered. Reset values: state IDLE, grant 0, done 0, busy 0, value 0, rr pointer 0.
- FSM states and transitions:
  - IDLE:
    - If any req is high, pick the winner by round-robin from the pointer (pointer, pointer+1, … mod NREQ).
    - Register grant (one-hot) and latch len of the winner.
    - Clear value to 0 and go to RUN.
    - Pointer becomes winner+1 mod NREQ.
  - RUN:
    - If value == latched len, go to DONE and hold value.
    - Otherwise increment value.
  - DONE:
    - done[owner] = 1 for this single cycle; grant and busy stay asserted.
    - Next state is IDLE with grant 0, busy 0, value 0.
- len is latched at grant. Later changes to len, including the owner's own len, are ignored until the next grant.
- Arithmetic is unsigned WIDTH-bit. value never exceeds latched len, so no wrap occurs. len = 2^WIDTH-1 is legal.
- len = 0: RUN lasts one cycle (value 0), then DONE.
- Requests that arrive during RUN or DONE wait. The pointer guarantees each active requester is served within NREQ grants.
- A req that rises and falls while the block is not in IDLE is never seen.
- The owner must hold req high until it sees done. Behaviour when req drops early is set by Configuration.
- If reset is asserted mid-run, everything returns to reset values asynchronously. No done is issued.

## Timing
- Arbitration latency: req is sampled high in IDLE at edge k, and grant/busy are high with value = 0 after edge k.
- Run length: L+1 RUN cycles (value 0..L), then 1 DONE cycle.
- done is high for exactly one cycle, following the cycle in which value = L.
- IDLE lasts at least 1 cycle between grants. Back-to-back occupancy per grant is L+3 cycles.
- grant never changes outside the IDLE→RUN and DONE→IDLE edges.
- done and grant of a given requester are never both low while busy is high.

## Configuration
- COUNTER_SCHED_ABORT_EN defined:
  - During RUN, if req[owner] is sampled low, the next state is IDLE.
  - grant, busy and value are cleared and no done pulse is issued.
  - Pointer already advanced at grant, so it is unaffected.
- Not defined:
  - A dropped req is ignored and the run completes.
  - The done pulse is still issued to the (now idle) owner.

## Structure
- Package counter_sched_pkg holds the state enum (IDLE, RUN, DONE) and the default NREQ/WIDTH constants.
- One sub-module, rr_arbiter:
  - Combinational one-hot round-robin pick from req and pointer.
  - Outputs the winner index and a valid flag.
- The counter register and FSM stay in counter_sched.

## Test plan
- Reset: hold reset=0 for 5 cycles with req=4'b1111 → grant=0, done=0, busy=0, value=0 throughout. Release → grant=4'b0001 one cycle later.
- Single run: req[2]=1, len[2]=5 → grant=4'b0100, value 0,1,2,3,4,5, done[2] pulse on the 7th cycle after grant, busy low the cycle after.
- Fairness: all req high, all len=1, requesters re-raise req after each done → grant order 0,1,2,3,0 with 4-cycle spacing. No requester is granted twice before the others.
- len=0 and len=255: len[1]=0 → one RUN cycle then done[1]. len[0]=255 → value reaches 255 without wrap, done[0] follows after 256 RUN cycles.
- Abort: len[3]=10, drop req[3] when value=4 → with COUNTER_SCHED_ABORT_EN, value=0, grant=0 next cycle, no done. Without the macro → run completes to 10 and done[3] pulses.
- Mid-run reset: assert reset at value=3 between clock edges → outputs clear immediately. After release with req[1] high → new grant to requester 1 (pointer reset to 0, so requester 1 wins only if req[0] is low).
